// File: rtl/issue_broadcaster.sv
// issue_broadcaster: streams one image from image memory onto the issue
// broadcast bus in raster order. Z is the outermost loop, then Y, with X
// innermost. Each beat carries its (x, y) tag. Z is implied by ordering.
// A 2-entry prefetch FIFO hides the 1-cycle memory latency, so the bus can
// carry one beat per cycle while allocators are not blocking.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               begin a pass (sampled only in IDLE)
//   img_width/height/depth  W/H/D dimensions, latched on start
//   mem_en, mem_addr    read strobe / linear address z*H*W + y*W + x
//   mem_data            read data, valid the cycle after mem_en
//   issue_a_x/y/data    current beat on the bus
//   issue_a_blocked     1 = bus empty (FIFO empty)
//   issue_a_block       OR of allocator blocks; 1 = hold current beat
//   busy, done          pass in progress / one-cycle completion pulse
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing reads, bus streaming
// DRAIN | all reads issued, emptying FIFO and in-flight read
// FIN   | done pulse, back to IDLE
module issue_broadcaster #(
  parameter int DATA_W  = 18,
  parameter int COORD_W = 8,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] img_width,
  input  logic [COORD_W-1:0] img_height,
  input  logic [COORD_W-1:0] img_depth,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic [COORD_W-1:0] issue_a_x,
  output logic [COORD_W-1:0] issue_a_y,
  output logic [DATA_W-1:0]  issue_a_data,
  output logic               issue_a_blocked,
  input  logic               issue_a_block,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t             state_q;
  logic [COORD_W-1:0] w_q, h_q, d_q;
  logic [COORD_W-1:0] x_q, y_q, z_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               infl_q;
  logic [COORD_W-1:0] infl_x_q, infl_y_q;
  logic [DATA_W-1:0]  fd_q [2];
  logic [COORD_W-1:0] fx_q [2];
  logic [COORD_W-1:0] fy_q [2];
  logic               wp_q, rp_q;
  logic [1:0]         cnt_q;

  logic               xfer, issue, x_end, y_end, last_rd;
  logic [1:0]         occ, cnt_d;
  logic [COORD_W-1:0] w_m1, h_m1, d_m1;

  always_comb begin
    w_m1    = w_q - 1'b1;
    h_m1    = h_q - 1'b1;
    d_m1    = d_q - 1'b1;
    xfer    = (cnt_q != 2'd0) && !issue_a_block;
    // Reserve a FIFO slot for every read in flight; a transfer this cycle
    // frees one, which keeps the stream at one beat per cycle.
    occ     = cnt_q + {1'b0, infl_q};
    issue   = (state_q == S_RUN) && ((occ < 2'd2) || xfer);
    cnt_d   = cnt_q + {1'b0, infl_q} - {1'b0, xfer};
    x_end   = (x_q == w_m1);
    y_end   = (y_q == h_m1);
    last_rd = x_end && y_end && (z_q == d_m1);
  end

  assign mem_en          = issue;
  assign mem_addr        = addr_q;
  assign issue_a_x       = fx_q[rp_q];
  assign issue_a_y       = fy_q[rp_q];
  assign issue_a_data    = fd_q[rp_q];
  assign issue_a_blocked = (cnt_q == 2'd0);
  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_FIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      d_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      addr_q   <= '0;
      infl_q   <= 1'b0;
      infl_x_q <= '0;
      infl_y_q <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fd_q[i] <= '0;
        fx_q[i] <= '0;
        fy_q[i] <= '0;
      end
    end else begin
      if (infl_q) begin
        fd_q[wp_q] <= mem_data;
        fx_q[wp_q] <= infl_x_q;
        fy_q[wp_q] <= infl_y_q;
        wp_q       <= ~wp_q;
      end
      if (xfer) rp_q <= ~rp_q;
      cnt_q  <= cnt_d;
      infl_q <= issue;

      if (issue) begin
        infl_x_q <= x_q;
        infl_y_q <= y_q;
        addr_q   <= addr_q + 1'b1;
        if (x_end) begin
          x_q <= '0;
          if (y_end) begin
            y_q <= '0;
            z_q <= z_q + 1'b1;
          end else begin
            y_q <= y_q + 1'b1;
          end
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q    <= img_width;
            h_q    <= img_height;
            d_q    <= img_depth;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            addr_q <= '0;
            if ((img_width == '0) || (img_height == '0) || (img_depth == '0))
              state_q <= S_FIN;
            else
              state_q <= S_RUN;
          end
        end
        S_RUN:   if (issue && last_rd) state_q <= S_DRAIN;
        // No reads issue in DRAIN, so an empty FIFO next cycle also means
        // nothing is left in flight.
        S_DRAIN: if (cnt_d == 2'd0 && !infl_q) state_q <= S_FIN;
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(infl_q && !xfer && cnt_q == 2'd2));

endmodule

// File: tb/tb_issue_broadcaster.sv
module tb_issue_broadcaster;

  localparam int DW = 18;
  localparam int CW = 8;
  localparam int AW = 16;

  logic          clk, rst, start;
  logic [CW-1:0] img_width, img_height, img_depth;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [CW-1:0] issue_a_x, issue_a_y;
  logic [DW-1:0] issue_a_data;
  logic          issue_a_blocked, issue_a_block;
  logic          busy, done;

  issue_broadcaster #(.DATA_W(DW), .COORD_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_width(img_width), .img_height(img_height), .img_depth(img_depth),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_a_x(issue_a_x), .issue_a_y(issue_a_y), .issue_a_data(issue_a_data),
    .issue_a_blocked(issue_a_blocked), .issue_a_block(issue_a_block),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [DW-1:0] d;
  } beat_t;

  beat_t sb[$];
  int    total = 0, bad = 0;
  int    cyc = 0;
  int    mem_mul = 1, mem_add = 100;
  int    exp_addr = 0, nreads = 0, nxfer = 0, nvalid = 0, ndone = 0, outst = 0;
  int    first_rd = -1, first_beat = -1, done_cyc = -1;
  bit    prev_stall = 0;
  beat_t prev_beat;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] memval(int a);
    return DW'(a * mem_mul + mem_add);
  endfunction

  // Image memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_en) mem_data <= memval(int'(mem_addr));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: raster walk of the whole image, Z outer, X inner.
  task automatic push_image(int w, int h, int d);
    beat_t b;
    for (int z = 0; z < d; z++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          b.x = CW'(x);
          b.y = CW'(y);
          b.d = memval((z * h + y) * w + x);
          sb.push_back(b);
        end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
      outst      = 0;
    end else begin
      beat_t e;
      if (!issue_a_blocked) nvalid++;
      if (mem_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", 64'(mem_addr), 64'(exp_addr));
        exp_addr++;
        nreads++;
        outst++;
      end
      if (prev_stall)
        chk("stall_stable", 64'({issue_a_blocked, issue_a_x, issue_a_y, issue_a_data}),
            64'({1'b0, prev_beat}));
      if (!issue_a_blocked && !issue_a_block) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("beat", 64'({issue_a_x, issue_a_y, issue_a_data}), 64'(e));
        end
        if (first_beat < 0) first_beat = cyc;
        nxfer++;
        outst--;
      end
      if (mem_en) chk("outstanding_le2", 64'(outst <= 2), 64'(1));
      prev_stall = !issue_a_blocked && issue_a_block;
      prev_beat  = {issue_a_x, issue_a_y, issue_a_data};
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk_reset_outputs(string name);
    chk(name, 64'({issue_a_blocked, issue_a_x, issue_a_y, issue_a_data, mem_en, mem_addr, busy, done}),
        64'({1'b1, 8'd0, 8'd0, 18'd0, 1'b0, 16'd0, 1'b0, 1'b0}));
  endtask

  // mode: 0 free-running, 1 random block, 2 hold beat 4 for 5 cycles,
  //       3 reset after 6 transfers, 4 stray start during RUN
  task automatic run_pass(int w, int h, int d, int mode);
    int t0, n, nd0, nx0, nr0, nv0, hold_left;
    bit held, fin;
    n = w * h * d;
    push_image(w, h, d);
    exp_addr = 0; first_rd = -1; first_beat = -1; done_cyc = -1;
    nd0 = ndone; nx0 = nxfer; nr0 = nreads; nv0 = nvalid;
    held = 0; hold_left = 0; fin = 0;
    @(posedge clk); #1;
    img_width = CW'(w); img_height = CW'(h); img_depth = CW'(d);
    start = 1; t0 = cyc;
    @(posedge clk); #1;
    start = 0;
    img_width = CW'($urandom); img_height = CW'($urandom); img_depth = CW'($urandom);
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (ndone != nd0) fin = 1;
      else begin
        issue_a_block = 0;
        start = 0;
        if (mode == 1) issue_a_block = 1'($urandom_range(0, 1));
        if (mode == 2) begin
          if (hold_left > 0 || (!held && nxfer - nx0 == 4)) begin
            if (!held) hold_left = 5;
            held = 1;
            issue_a_block = 1;
            chk("hold_beat4", 64'({issue_a_blocked, issue_a_x, issue_a_y, issue_a_data}),
                64'({1'b0, 8'd1, 8'd1, memval(4)}));
            hold_left--;
          end
        end
        if (mode == 3 && nxfer - nx0 == 6) begin
          rst = 0;
          #1;
          chk_reset_outputs("async_reset");
          @(posedge clk); #1;
          @(posedge clk); #1;
          chk_reset_outputs("reset_held");
          rst = 1;
          sb.delete();
          chk("no_done_on_abort", 64'(ndone - nd0), 64'(0));
          return;
        end
        if (mode == 4 && i == 3) begin
          img_width = 7; img_height = 7; img_depth = 7;
          start = 1;
        end
        @(posedge clk); #1;
      end
    end
    issue_a_block = 0;
    start = 0;
    chk("done_seen", 64'(fin), 64'(1));
    chk("done_count", 64'(ndone - nd0), 64'(1));
    chk("xfer_count", 64'(nxfer - nx0), 64'(n));
    chk("read_count", 64'(nreads - nr0), 64'(n));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    if (mode == 0 || mode == 4) begin
      if (n == 0) begin
        chk("done_lat_zero", 64'(done_cyc - t0), 64'(1));
        chk("no_valid_zero", 64'(nvalid - nv0), 64'(0));
      end else begin
        chk("first_rd_lat", 64'(first_rd - t0), 64'(1));
        chk("first_beat_lat", 64'(first_beat - t0), 64'(3));
        chk("done_lat", 64'(done_cyc - t0), 64'(3 + n));
      end
    end
    chk("idle_after_done", 64'({busy, done}), 64'(0));
  endtask

  initial begin
    rst = 0; start = 0; issue_a_block = 0;
    img_width = 0; img_height = 0; img_depth = 0;
    #1;
    chk_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1 rst = 1;

    mem_mul = 1; mem_add = 100;
    run_pass(3, 2, 2, 0);
    run_pass(3, 2, 2, 2);
    mem_mul = int'($urandom_range(1, 999)); mem_add = int'($urandom_range(0, 9999));
    run_pass(5, 5, 4, 1);
    run_pass(0, 4, 4, 0);
    mem_mul = 1; mem_add = 100;
    run_pass(3, 2, 2, 3);
    run_pass(3, 2, 2, 0);
    run_pass(3, 2, 2, 4);
    for (int k = 0; k < 4; k++) begin
      mem_mul = int'($urandom_range(1, 999)); mem_add = int'($urandom_range(0, 9999));
      run_pass(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 1)));
    end
    run_pass(1, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_broadcaster.md
Name: issue_broadcaster

Overview:
Issue-stage transmitter that drives the image broadcast bus consumed by every allocator.
- On start, it streams one image from image memory in strict raster order: Z outermost, then Y, then X innermost.
- Each pixel is presented on the bus with its (x, y) coordinate. Z is never sent; allocators recover it from ordering.
- It stalls on the OR-reduced block from all allocators.
- A small prefetch FIFO hides the 1-cycle memory read latency, so the bus sustains one beat per cycle.

Parameters:
- DATA_W, 18, pixel word width.
- COORD_W, 8, x/y coordinate and dimension width.
- ADDR_W, 16, image memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one image pass. Sampled only in IDLE.
- img_width  in  COORD_W  pixels per row (W). Latched on start.
- img_height  in  COORD_W  rows per plane (H). Latched on start.
- img_depth  in  COORD_W  planes (D). Latched on start.
- mem_en  out  1  image memory read strobe.
- mem_addr  out  ADDR_W  read address, linear z*H*W + y*W + x.
- mem_data  in  DATA_W  read data, valid exactly 1 cycle after mem_en.
- issue_a_x  out  COORD_W  broadcast x of current beat.
- issue_a_y  out  COORD_W  broadcast y of current beat.
- issue_a_data  out  DATA_W  broadcast pixel value.
- issue_a_blocked  out  1  1 = no valid beat on the bus; allocators must not capture.
- issue_a_block  in  1  OR of all allocator block outputs; 1 = hold the current beat.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - issue_a_blocked=1; issue_a_x/y/data=0.
  - mem_en=0; mem_addr=0.
  - busy=0; done=0.
  - FIFO emptied, counters cleared, FSM to IDLE.
  - Any pass in progress is abandoned; no partial completion is signalled.
- Beat transfer: occurs on a cycle where issue_a_blocked=0 and issue_a_block=0.
  - While issue_a_blocked=0 and issue_a_block=1, x/y/data stay stable.
  - issue_a_blocked never rises while a beat is pending.
- FSM:
  - IDLE: start=1 latches W/H/D, clears address and coordinate counters, goes to RUN. If any dimension is 0, go straight to FIN instead.
  - RUN: issue reads. After the read for beat W*H*D-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the FIFO is empty and no read is in flight after the final transfer, go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Prefetch FIFO: 2 entries.
  - A read issues in RUN when (fifo_count + inflight < 2) or a transfer occurs this cycle. This gives full throughput.
  - Returned mem_data is written into the FIFO with its x/y tag.
  - The FIFO head drives the bus. issue_a_blocked = FIFO empty.
  - The FIFO never overflows. Overflow is an assertion failure.
- Latency:
  - start accepted at cycle T.
  - First mem_en at T+1 with addr 0.
  - First beat on the bus at T+3.
  - Unblocked, consecutive beats follow every cycle.
  - done at the cycle after the final transfer.
- Counters:
  - mem_addr increments by 1 per read.
  - The x tag wraps at W-1 to 0 and increments y. y wraps at H-1 to 0 and increments z.
  - Terminate after z = D-1, y = H-1, x = W-1.
  - W*H*D must be ≤ 2^ADDR_W; larger is unsupported and undefined.
- start while not IDLE: ignored. Dimension inputs changing mid-pass have no effect.

Test Plan:
1. W=3, H=2, D=2, block=0, mem[a]=a+100 -> 12 consecutive beats from T+3:
   - (x,y) = (0,0) (1,0) (2,0) (0,1) (1,1) (2,1), then the same six again.
   - data = 100..111; mem_addr 0..11.
   - done pulse at T+15; busy low afterwards.
2. Same image, issue_a_block held high 5 cycles while beat 4 is presented -> beat 4 (x=1, y=1, data=104) stays stable with issue_a_blocked=0; no more than 2 reads outstanding; beat 5 follows after release; no loss or duplication.
3. W=5, H=5, D=4, issue_a_block random at 50% -> exactly 100 transfers in raster order, data matching mem, single done pulse.
4. W=0, H=4, D=4, start -> done at T+1, mem_en never asserted, issue_a_blocked stays 1.
5. rst driven low for 2 cycles after beat 6 of scenario 1 -> all outputs take reset values immediately (asynchronously); a new start replays from addr 0, x=0, y=0.
6. start pulsed during RUN with different dimensions -> ignored; the original 12-beat sequence completes unchanged.
